// File: rtl/prog_loader_pkg.sv
// Shared definitions for the program loader: FSM encoding, word geometry
// and the byte-lane insert helper used by the packer.
package prog_loader_pkg;

   localparam int BYTES_PER_WORD = 4;

   typedef logic [2:0] state_t;

   localparam state_t ST_IDLE    = 3'd0;
   localparam state_t ST_COLLECT = 3'd1;
   localparam state_t ST_WRITE   = 3'd2;
   localparam state_t ST_DONE    = 3'd3;
   localparam state_t ST_ERR     = 3'd4;

   function automatic logic [31:0] put_lane(input logic [31:0] word,
                                            input logic [1:0]  lane,
                                            input logic [7:0]  data);
      logic [31:0] res;
      res = word;
      res[{lane, 3'b000} +: 8] = data;
      return res;
   endfunction

endpackage

// File: rtl/byte_packer.sv
// Assembles little-endian bytes into a 32-bit word; lane 0 is bits [7:0].
// full flags that the next push lands in the top lane.
module byte_packer
   import prog_loader_pkg::*;
(
   input  logic        clk,
   input  logic        reset_n,
   input  logic        clr,
   input  logic        push,
   input  logic [7:0]  byteIn,
   output logic [31:0] word,
   output logic        full
);

   localparam logic [1:0] LAST_LANE = 2'(BYTES_PER_WORD - 1);

   logic [31:0] word_r;
   logic [1:0]  idx_r;

   // Word register and lane index; clear wins over push.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         word_r <= 32'd0;
         idx_r  <= 2'd0;
      end else if (clr) begin
         word_r <= 32'd0;
         idx_r  <= 2'd0;
      end else if (push) begin
         word_r <= put_lane(word_r, idx_r, byteIn);
         idx_r  <= idx_r + 2'd1;
      end else begin
         word_r <= word_r;
         idx_r  <= idx_r;
      end
   end

   assign word = word_r;
   assign full = (idx_r == LAST_LANE);

endmodule

// File: rtl/prog_loader.sv
// Streams a byte-wise program into instruction memory one word at a time,
// holding the fetch unit in reset until the final word has been committed.
module prog_loader
   import prog_loader_pkg::*;
#(
   parameter int widthMem   = 32,
   parameter int START_ADDR = 0,
   parameter int LAST_ADDR  = 8188
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                start,
   input  logic [7:0]          byteIn,
   input  logic                byteValid,
   input  logic                byteLast,
   output logic                byteReady,
   output logic [widthMem-1:0] writeAddr,
   output logic [widthMem-1:0] writeData,
   output logic                wr,
   output logic                cpuHold,
   output logic                done,
   output logic                error,
   output logic [11:0]         wordCount
);

   localparam logic [widthMem-1:0] START_A = widthMem'(START_ADDR);
   localparam logic [widthMem-1:0] LAST_A  = widthMem'(LAST_ADDR);
   localparam logic [widthMem-1:0] STEP_A  = widthMem'(BYTES_PER_WORD);

   state_t              state_r, state_nxt_s;
   logic [widthMem-1:0] cur_addr_r, write_addr_r;
   logic [11:0]         word_count_r;
   logic                last_seen_r, byte_ready_r, wr_r, cpu_hold_r, done_r, error_r;
   logic [31:0]         word_s;
   logic                full_s, push_s, clr_s, load_s, advance_s, enter_write_s, addr_ok_s;

   assign addr_ok_s = (cur_addr_r <= LAST_A);

   byte_packer u_packer (
      .clk     (clk),
      .reset_n (reset_n),
      .clr     (clr_s),
      .push    (push_s),
      .byteIn  (byteIn),
      .word    (word_s),
      .full    (full_s)
   );

   // Next-state and datapath control decode.
   always_comb begin
      state_nxt_s   = state_r;
      push_s        = 1'b0;
      clr_s         = 1'b0;
      load_s        = 1'b0;
      advance_s     = 1'b0;
      enter_write_s = 1'b0;
      case (state_r)
         ST_IDLE, ST_DONE, ST_ERR: begin
            if (start) begin
               state_nxt_s = ST_COLLECT;
               load_s      = 1'b1;
               clr_s       = 1'b1;
            end else begin
               state_nxt_s = state_r;
            end
         end
         ST_COLLECT: begin
            if (byteValid && byte_ready_r) begin
               push_s = 1'b1;
               if (full_s || byteLast) begin
                  state_nxt_s   = ST_WRITE;
                  enter_write_s = 1'b1;
               end else begin
                  state_nxt_s = state_r;
               end
            end else begin
               state_nxt_s = state_r;
            end
         end
         ST_WRITE: begin
            clr_s = 1'b1;
            if (addr_ok_s) begin
               advance_s   = 1'b1;
               state_nxt_s = last_seen_r ? ST_DONE : ST_COLLECT;
            end else begin
               state_nxt_s = ST_ERR;
            end
         end
         default: state_nxt_s = ST_IDLE;
      endcase
   end

   // State, counters and output registers; outputs are loaded from the
   // next state so they line up with the state they describe.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_r      <= ST_IDLE;
         cur_addr_r   <= START_A;
         word_count_r <= 12'd0;
         last_seen_r  <= 1'b0;
         byte_ready_r <= 1'b0;
         wr_r         <= 1'b0;
         write_addr_r <= '0;
         cpu_hold_r   <= 1'b1;
         done_r       <= 1'b0;
         error_r      <= 1'b0;
      end else begin
         state_r      <= state_nxt_s;
         byte_ready_r <= (state_nxt_s == ST_COLLECT);
         wr_r         <= enter_write_s && addr_ok_s;
         cpu_hold_r   <= (state_nxt_s != ST_DONE);
         done_r       <= (state_nxt_s == ST_DONE);
         error_r      <= (state_nxt_s == ST_ERR);
         if (enter_write_s) begin
            write_addr_r <= cur_addr_r;
            last_seen_r  <= byteLast;
         end else if (load_s) begin
            last_seen_r  <= 1'b0;
         end
         if (load_s) begin
            cur_addr_r   <= START_A;
            word_count_r <= 12'd0;
         end else if (advance_s) begin
            cur_addr_r <= cur_addr_r + STEP_A;
            if (word_count_r != 12'hFFF) begin
               word_count_r <= word_count_r + 12'd1;
            end
         end
      end
   end

   assign byteReady = byte_ready_r;
   assign wr        = wr_r;
   assign writeAddr = write_addr_r;
   assign writeData = widthMem'(word_s);
   assign cpuHold   = cpu_hold_r;
   assign done      = done_r;
   assign error     = error_r;
   assign wordCount = word_count_r;

endmodule

// File: tb/tb_prog_loader.sv
// Scoreboard bench for prog_loader: instance 0 uses default parameters,
// instance 1 starts near the top of memory to reach the overflow path.
module tb_prog_loader;

   logic        clk = 1'b0;
   logic        reset_n [2];
   logic        start_v [2];
   logic [7:0]  byte_in [2];
   logic        byte_valid [2];
   logic        byte_last [2];
   logic        byte_ready [2];
   logic [31:0] write_addr [2];
   logic [31:0] write_data [2];
   logic        wr [2];
   logic        cpu_hold [2];
   logic        done_v [2];
   logic        error_v [2];
   logic [11:0] word_count [2];

   int checks = 0;
   int errors = 0;
   int wr_cnt [2];
   logic [63:0] q0 [$];
   logic [63:0] q1 [$];

   always #5 clk = ~clk;

   prog_loader u0 (
      .clk(clk), .reset_n(reset_n[0]), .start(start_v[0]), .byteIn(byte_in[0]),
      .byteValid(byte_valid[0]), .byteLast(byte_last[0]), .byteReady(byte_ready[0]),
      .writeAddr(write_addr[0]), .writeData(write_data[0]), .wr(wr[0]),
      .cpuHold(cpu_hold[0]), .done(done_v[0]), .error(error_v[0]), .wordCount(word_count[0])
   );

   prog_loader #(.widthMem(32), .START_ADDR(8184), .LAST_ADDR(8188)) u1 (
      .clk(clk), .reset_n(reset_n[1]), .start(start_v[1]), .byteIn(byte_in[1]),
      .byteValid(byte_valid[1]), .byteLast(byte_last[1]), .byteReady(byte_ready[1]),
      .writeAddr(write_addr[1]), .writeData(write_data[1]), .wr(wr[1]),
      .cpuHold(cpu_hold[1]), .done(done_v[1]), .error(error_v[1]), .wordCount(word_count[1])
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic expect_wr(input int d, input logic [31:0] addr, input logic [31:0] data);
      if (d == 0) q0.push_back({addr, data});
      else        q1.push_back({addr, data});
   endtask

   // Monitor: every write strobe pops the scoreboard and is checked.
   always @(negedge clk) begin
      logic [63:0] e;
      for (int d = 0; d < 2; d++) begin
         if (wr[d]) begin
            wr_cnt[d]++;
            if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
               checks++;
               errors++;
               $display("FAIL unexpected_wr dut%0d: got addr %h data %h expected no write",
                        d, write_addr[d], write_data[d]);
            end else begin
               if (d == 0) e = q0.pop_front();
               else        e = q1.pop_front();
               chk($sformatf("wr_addr dut%0d", d), write_addr[d], e[63:32]);
               chk($sformatf("wr_data dut%0d", d), write_data[d], e[31:0]);
            end
            chk($sformatf("ready_in_write dut%0d", d), 32'(byte_ready[d]), 32'd0);
            chk($sformatf("hold_in_write dut%0d", d), 32'(cpu_hold[d]), 32'd1);
         end
      end
   end

   task automatic chk_reset(input int d);
      chk("rst_byteReady", 32'(byte_ready[d]), 32'd0);
      chk("rst_wr",        32'(wr[d]),         32'd0);
      chk("rst_writeAddr", write_addr[d],      32'd0);
      chk("rst_writeData", write_data[d],      32'd0);
      chk("rst_cpuHold",   32'(cpu_hold[d]),   32'd1);
      chk("rst_done",      32'(done_v[d]),     32'd0);
      chk("rst_error",     32'(error_v[d]),    32'd0);
      chk("rst_wordCount", 32'(word_count[d]), 32'd0);
   endtask

   task automatic pulse_start(input int d);
      @(negedge clk);
      start_v[d] = 1'b1;
      @(posedge clk);
      #1 start_v[d] = 1'b0;
      @(negedge clk);
      chk("start_to_ready", 32'(byte_ready[d]), 32'd1);
   endtask

   task automatic send(input int d, input logic [7:0] b, input logic last, input int gap);
      int n;
      n = 0;
      repeat (gap) @(negedge clk);
      @(negedge clk);
      byte_in[d]    = b;
      byte_valid[d] = 1'b1;
      byte_last[d]  = last;
      while (!byte_ready[d] && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (n >= 100) begin
         checks++;
         errors++;
         $display("FAIL send_timeout dut%0d: byte %h not accepted within 100 cycles", d, b);
      end
      @(posedge clk);
      #1;
      byte_valid[d] = 1'b0;
      byte_last[d]  = 1'b0;
   endtask

   task automatic wait_flag(input int d, input bit want_err);
      int n;
      n = 0;
      while (n < 50 && !(want_err ? error_v[d] : done_v[d])) begin
         @(negedge clk);
         n++;
      end
      chk(want_err ? "wait_error" : "wait_done",
          32'(want_err ? error_v[d] : done_v[d]), 32'd1);
   endtask

   initial begin
      int base;
      int gaps [8];
      logic idle_ready;
      gaps = '{0, 2, 1, 3, 0, 1, 2, 0};
      for (int d = 0; d < 2; d++) begin
         reset_n[d] = 1'b0; start_v[d] = 1'b0; byte_in[d] = 8'h00;
         byte_valid[d] = 1'b0; byte_last[d] = 1'b0; wr_cnt[d] = 0;
      end
      repeat (3) @(negedge clk);
      chk_reset(0);
      chk_reset(1);
      reset_n[0] = 1'b1;
      reset_n[1] = 1'b1;

      // Full-word load
      base = wr_cnt[0];
      expect_wr(0, 32'd0, 32'h0050_0013);
      pulse_start(0);
      send(0, 8'h13, 1'b0, 0);
      send(0, 8'h00, 1'b0, 0);
      send(0, 8'h50, 1'b0, 0);
      send(0, 8'h00, 1'b1, 0);
      wait_flag(0, 1'b0);
      chk("full_cpuHold", 32'(cpu_hold[0]), 32'd0);
      chk("full_wordCount", 32'(word_count[0]), 32'd1);
      chk("full_wr_pulses", 32'(wr_cnt[0] - base), 32'd1);

      // Partial final word
      base = wr_cnt[0];
      expect_wr(0, 32'd0, 32'h0403_0201);
      expect_wr(0, 32'd4, 32'h0000_0605);
      pulse_start(0);
      for (int i = 1; i <= 6; i++) send(0, 8'(i), (i == 6), 0);
      wait_flag(0, 1'b0);
      chk("partial_wordCount", 32'(word_count[0]), 32'd2);
      chk("partial_wr_pulses", 32'(wr_cnt[0] - base), 32'd2);

      // Backpressure and gaps
      base = wr_cnt[0];
      expect_wr(0, 32'd0, 32'hA3A2_A1A0);
      expect_wr(0, 32'd4, 32'hA7A6_A5A4);
      pulse_start(0);
      for (int i = 0; i < 8; i++) send(0, 8'hA0 + 8'(i), (i == 7), gaps[i]);
      wait_flag(0, 1'b0);
      chk("bp_wordCount", 32'(word_count[0]), 32'd2);
      chk("bp_wr_pulses", 32'(wr_cnt[0] - base), 32'd2);

      // Reload from DONE
      base = wr_cnt[0];
      expect_wr(0, 32'd0, 32'hEFBE_ADDE);
      pulse_start(0);
      chk("reload_cpuHold", 32'(cpu_hold[0]), 32'd1);
      chk("reload_done", 32'(done_v[0]), 32'd0);
      chk("reload_wordCount", 32'(word_count[0]), 32'd0);
      send(0, 8'hDE, 1'b0, 0);
      send(0, 8'hAD, 1'b0, 0);
      send(0, 8'hBE, 1'b0, 0);
      send(0, 8'hEF, 1'b1, 0);
      wait_flag(0, 1'b0);
      chk("reload_wr_pulses", 32'(wr_cnt[0] - base), 32'd1);

      // Reset mid-load
      base = wr_cnt[0];
      pulse_start(0);
      send(0, 8'h11, 1'b0, 0);
      send(0, 8'h22, 1'b0, 0);
      @(negedge clk);
      reset_n[0] = 1'b0;
      @(negedge clk);
      chk_reset(0);
      reset_n[0] = 1'b1;
      byte_in[0] = 8'h77;
      byte_valid[0] = 1'b1;
      idle_ready = 1'b0;
      repeat (6) begin
         @(negedge clk);
         idle_ready = idle_ready | byte_ready[0];
      end
      byte_valid[0] = 1'b0;
      chk("idle_ready_after_reset", 32'(idle_ready), 32'd0);
      chk("midreset_wr_pulses", 32'(wr_cnt[0] - base), 32'd0);
      expect_wr(0, 32'd0, 32'h3433_3231);
      pulse_start(0);
      for (int i = 1; i <= 4; i++) send(0, 8'h30 + 8'(i), (i == 4), 0);
      wait_flag(0, 1'b0);
      chk("postreset_wordCount", 32'(word_count[0]), 32'd1);

      // Overflow near the top of memory
      base = wr_cnt[1];
      expect_wr(1, 32'd8184, 32'h0302_0100);
      expect_wr(1, 32'd8188, 32'h0706_0504);
      pulse_start(1);
      for (int i = 0; i < 12; i++) send(1, 8'(i), 1'b0, 0);
      wait_flag(1, 1'b1);
      repeat (4) @(negedge clk);
      chk("ovf_error", 32'(error_v[1]), 32'd1);
      chk("ovf_cpuHold", 32'(cpu_hold[1]), 32'd1);
      chk("ovf_done", 32'(done_v[1]), 32'd0);
      chk("ovf_byteReady", 32'(byte_ready[1]), 32'd0);
      chk("ovf_wordCount", 32'(word_count[1]), 32'd2);
      chk("ovf_wr_pulses", 32'(wr_cnt[1] - base), 32'd2);

      repeat (3) @(negedge clk);
      chk("sb0_drained", 32'(q0.size()), 32'd0);
      chk("sb1_drained", 32'(q1.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
